// File: rtl/pipo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipo_ctrl_pkg
// Shared types, limits and the round-robin pick function used by the
// pipo_rr_ctrl controller and its rr_arbiter sub-module.
//   state_t  : occupancy of the shared parallel register (EMPTY / FULL)
//   MAX_NREQ : largest supported requester count
//   STAT_W   : width of the optional transfer counter
//   rr_pick  : one-hot grant of the first valid requester after ptr
// -----------------------------------------------------------------------------
package pipo_ctrl_pkg;

  localparam int MAX_NREQ = 8;
  localparam int STAT_W   = 16;
  localparam int PTR_W    = $clog2(MAX_NREQ);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Scans ptr+1, ptr+2, ... with wrap-around and returns the first valid bit
  // as a one-hot vector. Requester counts below MAX_NREQ work unchanged:
  // the unused upper valid bits are zero, so the scan runs past them and
  // wraps to requester 0 exactly as a NREQ-wide scan would.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [PTR_W-1:0]    ptr
  );
    logic [MAX_NREQ-1:0] grant;
    logic [PTR_W-1:0]    idx;
    grant = '0;
    for (int i = 1; i <= MAX_NREQ; i++) begin
      idx = ptr + PTR_W'(i);
      if ((grant == '0) && valid[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/pipo_rr_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick plus the registered priority pointer.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   en         : a load may be granted this cycle
//   req_valid  : per-requester request flags
//   grant      : one-hot grant (all zero when en is low or nothing is valid)
//   grant_idx  : binary index of the granted requester
//   load       : any grant bit set
// The pointer holds the last granted index; reset leaves it at NREQ-1 so
// requester 0 is first in line.
// -----------------------------------------------------------------------------
module rr_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             load
);

  logic [IDX_W-1:0]    ptr;
  logic [MAX_NREQ-1:0] valid_pad;
  logic [PTR_W-1:0]    ptr_pad;
  logic [MAX_NREQ-1:0] pick;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_pad             = '0;
    valid_pad[NREQ-1:0]   = req_valid;
    ptr_pad               = '0;
    ptr_pad[IDX_W-1:0]    = ptr;
    pick                  = rr_pick(valid_pad, ptr_pad);
    grant                 = en ? pick[NREQ-1:0] : '0;
    grant_idx             = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
    load = |grant;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement or block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= IDX_W'(NREQ - 1);
    end else if (load) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/pipo_rr_ctrl.sv
// -----------------------------------------------------------------------------
// pipo_rr_ctrl
// Round-robin load sequencer for one WIDTH-bit parallel-in/parallel-out
// register shared by NREQ requesters. Grants one valid requester per load
// opportunity, captures its word and offers it downstream with valid/ready.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   req_valid  : per-requester word offered
//   req_data   : packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot grant, combinational
//   po         : shared register contents
//   po_valid   : po holds an unconsumed word
//   po_src     : requester that loaded po
//   po_ready   : downstream accepts po
//   xfer_cnt   : saturating load count (only with PIPO_RR_CTRL_STATS_EN)
// Optional feature macro: PIPO_RR_CTRL_STATS_EN.
// MIN_GAP forces that many idle cycles after each load before the next grant.
// -----------------------------------------------------------------------------
module pipo_rr_ctrl
  import pipo_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int MIN_GAP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        po,
  output logic                    po_valid,
  output logic [$clog2(NREQ)-1:0] po_src,
  input  logic                    po_ready
`ifdef PIPO_RR_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]       xfer_cnt
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  state_t           state;
  logic [3:0]       gap_cnt;
  logic             can_load;
  logic             load;
  logic [IDX_W-1:0] grant_idx;

  // A slot opens when the register is empty or being drained this cycle,
  // and the post-load gap has expired.
  assign can_load = ((state == ST_EMPTY) || po_ready) && (gap_cnt == 4'd0);

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (can_load),
    .req_valid (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .load      (load)
  );

  // A load while FULL implies po_ready, so it covers the back-to-back case:
  // the old word leaves and the new one enters on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_EMPTY;
      po      <= '0;
      po_src  <= '0;
      gap_cnt <= '0;
    end else begin
      if (load) begin
        po      <= req_data[grant_idx*WIDTH +: WIDTH];
        po_src  <= grant_idx;
        state   <= ST_FULL;
        gap_cnt <= 4'(MIN_GAP);
      end else begin
        if ((state == ST_FULL) && po_ready) state <= ST_EMPTY;
        if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  assign po_valid = (state == ST_FULL);

`ifdef PIPO_RR_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= '0;
    end else if (load && (xfer_cnt != {STAT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipo_rr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipo_rr_ctrl
// Directed bench for pipo_rr_ctrl. Expected words are queued as loads are
// granted; a monitor pops and compares each word as downstream consumes it.
// A second instance with MIN_GAP=2 exercises the forced idle cycles.
// Optional feature macro: PIPO_RR_CTRL_STATS_EN.
// -----------------------------------------------------------------------------
module tb_pipo_rr_ctrl;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  po;
  logic        po_valid;
  logic [1:0]  po_src;
  logic        po_ready;

  logic [3:0]  g_valid;
  logic [15:0] g_data;
  logic [3:0]  g_ready;
  logic [3:0]  g_po;
  logic        g_po_valid;
  logic [1:0]  g_po_src;
  logic        g_po_ready;

`ifdef PIPO_RR_CTRL_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] g_xfer_cnt;
`endif

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipo_rr_ctrl #(.NREQ(4), .WIDTH(4), .MIN_GAP(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .po        (po),
    .po_valid  (po_valid),
    .po_src    (po_src),
    .po_ready  (po_ready)
`ifdef PIPO_RR_CTRL_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  pipo_rr_ctrl #(.NREQ(4), .WIDTH(4), .MIN_GAP(2)) dut_gap (
    .clk       (clk),
    .rst       (rst),
    .req_valid (g_valid),
    .req_data  (g_data),
    .req_ready (g_ready),
    .po        (g_po),
    .po_valid  (g_po_valid),
    .po_src    (g_po_src),
    .po_ready  (g_po_ready)
`ifdef PIPO_RR_CTRL_STATS_EN
    ,
    .xfer_cnt  (g_xfer_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] data, input logic [1:0] src);
    exp_q.push_back('{data: data, src: src});
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Scoreboard monitor: compares on each downstream handshake, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst && po_valid && po_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_extra: got po=%0h src=%0d, expected no word", po, po_src);
      end else begin
        e = exp_q.pop_front();
        check("sb_po", {28'd0, po}, {28'd0, e.data});
        check("sb_src", {30'd0, po_src}, {30'd0, e.src});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    po_ready   = 1'b0;
    g_valid    = '0;
    g_data     = 16'h4321;
    g_po_ready = 1'b1;

    // Reset state
    #2;
    check("rst_po", {28'd0, po}, 32'd0);
    check("rst_po_valid", {31'd0, po_valid}, 32'd0);
    check("rst_po_src", {30'd0, po_src}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    step();
    step();
    rst = 1'b1;

    // Single request: same-cycle grant, word visible one cycle later
    req_valid = 4'b0100;
    req_data  = 16'h0A00;
    po_ready  = 1'b1;
    #1;
    check("single_req_ready", {28'd0, req_ready}, 32'h4);
    push(4'hA, 2'd2);
    step();
    check("single_po", {28'd0, po}, 32'hA);
    check("single_po_src", {30'd0, po_src}, 32'd2);
    check("single_po_valid", {31'd0, po_valid}, 32'd1);
    req_valid = '0;
    step();

    // Fairness from a fresh pointer: 0,1,2,3,0
    reset_pulse();
    req_data  = 16'h4321;
    req_valid = 4'hF;
    po_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fair_req_ready", {28'd0, req_ready}, 32'(1 << (k % 4)));
      push(4'((k % 4) + 1), 2'(k % 4));
      step();
    end
    req_valid = '0;
    step();
    step();

    // Backpressure: word 9 held, no grants until po_ready returns
    req_valid = 4'b0010;
    req_data  = 16'h0090;
    po_ready  = 1'b0;
    #1;
    check("bp_load_req_ready", {28'd0, req_ready}, 32'h2);
    push(4'h9, 2'd1);
    step();
    check("bp_po_valid", {31'd0, po_valid}, 32'd1);
    req_valid = 4'b0011;
    req_data  = 16'h0056;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold_req_ready", {28'd0, req_ready}, 32'd0);
      check("bp_hold_po", {28'd0, po}, 32'h9);
      step();
    end
    po_ready = 1'b1;
    #1;
    check("bp_release_req_ready", {28'd0, req_ready}, 32'h1);
    push(4'h6, 2'd0);
    step();
    check("bp_new_po", {28'd0, po}, 32'h6);
    check("bp_new_po_src", {30'd0, po_src}, 32'd0);
    req_valid = '0;
    step();
    step();

    // Mid-operation reset while FULL discards the held word
    req_valid = 4'hF;
    req_data  = 16'h4321;
    po_ready  = 1'b0;
    #1;
    check("mrst_pre_req_ready", {28'd0, req_ready}, 32'h2);
    step();
    check("mrst_pre_po_valid", {31'd0, po_valid}, 32'd1);
    check("mrst_pre_po", {28'd0, po}, 32'h2);
    req_valid = '0;
    #2;
    rst = 1'b0;
    #1;
    check("mrst_po", {28'd0, po}, 32'd0);
    check("mrst_po_valid", {31'd0, po_valid}, 32'd0);
    check("mrst_po_src", {30'd0, po_src}, 32'd0);
    check("mrst_req_ready", {28'd0, req_ready}, 32'd0);
    step();
    rst       = 1'b1;
    req_valid = 4'hF;
    po_ready  = 1'b1;
    #1;
    check("mrst_first_grant", {28'd0, req_ready}, 32'h1);
    push(4'h1, 2'd0);
    step();
    check("mrst_first_po", {28'd0, po}, 32'h1);
    req_valid = '0;
    step();
    step();

    // MIN_GAP=2: a load every third cycle, grants 0,1,2
    g_valid = 4'hF;
    for (int k = 0; k < 9; k++) begin
      #1;
      check("gap_req_ready", {28'd0, g_ready},
            (k % 3 == 0) ? 32'(1 << (k / 3)) : 32'd0);
      if (k % 3 == 1) begin
        check("gap_po", {28'd0, g_po}, 32'((k / 3) + 1));
        check("gap_po_src", {30'd0, g_po_src}, 32'(k / 3));
        check("gap_po_valid", {31'd0, g_po_valid}, 32'd1);
      end
      step();
    end
    g_valid = '0;
    step();

`ifdef PIPO_RR_CTRL_STATS_EN
    // Transfer counter saturation
    reset_pulse();
    req_valid = 4'hF;
    req_data  = 16'h4321;
    po_ready  = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      push(4'((k % 4) + 1), 2'(k % 4));
      step();
    end
    req_valid = '0;
    step();
    step();
    check("stats_saturate", {16'd0, xfer_cnt}, 32'hFFFF);
`endif

    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
